// File: rtl/alu_control_seq.sv
// alu_control_seq: registered, handshaked LEGv8 ALU control decoder.
// Define ALUCTL_MUL_EN to decode MUL and sequence it over MUL_CYCLES; otherwise MUL decodes as illegal.
module alu_control_seq #(
    parameter int OPCODE_W   = 11,
    parameter int CTRL_W     = 4,
    parameter int MUL_CYCLES = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [1:0]          ALUop,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                InValid,
    output logic                InReady,
    output logic [CTRL_W-1:0]   ALUCtrl,
    output logic                OutValid,
    input  logic                OutReady,
    output logic                Busy,
    output logic                Illegal
);
`ifdef ALUCTL_MUL_EN
    localparam int CNT_W = $clog2(MUL_CYCLES + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, MULTI = 2'd1, VALID = 2'd2} state_t;
    logic [CNT_W-1:0] cnt;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, VALID = 2'd2} state_t;
`endif
    state_t      state;
    logic [3:0]  dec;
    logic [10:0] op;
    assign op = Opcode[10:0];
    always_comb begin
        dec = 4'b1111;
        case (ALUop)
            2'b00: dec = 4'b0010;
            2'b01: dec = 4'b0111;
            2'b10:
                case (op)
                    11'b10001011000: dec = 4'b0010;
                    11'b11001011000: dec = 4'b0110;
                    11'b10001010000: dec = 4'b0000;
                    11'b10101010000: dec = 4'b0001;
                    11'b11001010000: dec = 4'b0011;
                    11'b11010011011: dec = 4'b1000;
                    11'b11010011010: dec = 4'b1001;
`ifdef ALUCTL_MUL_EN
                    11'b10011011000: dec = 4'b1100;
`endif
                    default:         dec = 4'b1111;
                endcase
            default:
                case (op[10:1])
                    10'b1001000100: dec = 4'b0010;
                    10'b1101000100: dec = 4'b0110;
                    10'b1001001000: dec = 4'b0000;
                    10'b1011001000: dec = 4'b0001;
                    default:        dec = 4'b1111;
                endcase
        endcase
    end
    assign InReady = (state == IDLE) || (state == VALID && OutReady);
    // 1111 is produced only for undefined ops, 1100 only for MUL
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            ALUCtrl  <= '0;
            OutValid <= 1'b0;
            Illegal  <= 1'b0;
`ifdef ALUCTL_MUL_EN
            Busy     <= 1'b0;
            cnt      <= '0;
`endif
        end else if (InValid && InReady) begin
            ALUCtrl <= CTRL_W'(dec);
            Illegal <= dec == 4'b1111;
`ifdef ALUCTL_MUL_EN
            if (dec == 4'b1100) begin
                state    <= MULTI;
                OutValid <= 1'b0;
                Busy     <= 1'b1;
                cnt      <= CNT_W'(MUL_CYCLES - 1);
            end else begin
                state    <= VALID;
                OutValid <= 1'b1;
                Busy     <= 1'b0;
            end
`else
            state    <= VALID;
            OutValid <= 1'b1;
`endif
        end
`ifdef ALUCTL_MUL_EN
        else if (state == MULTI) begin
            if (cnt == '0) begin
                state    <= VALID;
                OutValid <= 1'b1;
                Busy     <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
`endif
        else if (state == VALID && OutReady) begin
            state    <= IDLE;
            OutValid <= 1'b0;
        end
    end
`ifndef ALUCTL_MUL_EN
    assign Busy = 1'b0;
`endif
endmodule

// File: tb/tb_alu_control_seq.sv
// tb_alu_control_seq: directed vectors checked against a cycle-count model of the ALU control sequencer.
module tb_alu_control_seq;
    logic        Clk = 1'b0, Reset = 1'b0;
    logic [1:0]  ALUop = 2'b00;
    logic [10:0] Opcode = '0;
    logic        InValid = 1'b0, OutReady = 1'b1;
    logic        InReady, OutValid, Busy, Illegal;
    logic [3:0]  ALUCtrl;
    int vectors = 0, errs = 0;
`ifdef ALUCTL_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif
    localparam int MULC = 4;
    localparam logic [10:0] ROPS [0:7] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                                           11'b11001010000, 11'b11010011011, 11'b11010011010, 11'b10011011000};
    localparam logic [3:0]  RCTL [0:7] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd3, 4'd8, 4'd9, 4'd12};
    localparam logic [9:0]  IOPS [0:3] = '{10'b1001000100, 10'b1101000100, 10'b1001001000, 10'b1011001000};
    localparam logic [3:0]  ICTL [0:3] = '{4'd2, 4'd6, 4'd0, 4'd1};
    localparam logic [10:0] MUL_OP = 11'b10011011000;

    alu_control_seq #(.MUL_CYCLES(MULC)) dut (
        .Clk(Clk), .Reset(Reset), .ALUop(ALUop), .Opcode(Opcode), .InValid(InValid),
        .InReady(InReady), .ALUCtrl(ALUCtrl), .OutValid(OutValid), .OutReady(OutReady),
        .Busy(Busy), .Illegal(Illegal)
    );

    always #5 Clk = ~Clk;

    task automatic chk4(input string name, input logic [3:0] got, input logic [3:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %b, expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Reference decode: control word, illegal flag and result latency in cycles
    task automatic ref_dec(input logic [1:0] a, input logic [10:0] op,
                           output logic [3:0] c, output bit il, output int lat);
        c = 4'd15; il = 1'b1; lat = 1;
        if (a == 2'd0) begin c = 4'd2; il = 1'b0; end
        else if (a == 2'd1) begin c = 4'd7; il = 1'b0; end
        else if (a == 2'd2) begin
            for (int i = 0; i < 8; i++)
                if (op == ROPS[i] && (i != 7 || MUL_EN)) begin
                    c = RCTL[i]; il = 1'b0; lat = (i == 7) ? MULC : 1;
                end
        end else begin
            for (int i = 0; i < 4; i++)
                if (op[10:1] == IOPS[i]) begin c = ICTL[i]; il = 1'b0; end
        end
    endtask

    // Model: a held result becomes visible at an absolute cycle number
    int cyc = 0, ready_cyc = 0, d_lat;
    bit have = 1'b0, m_ill = 1'b0, d_il;
    logic [3:0] m_ctrl = '0, d_c;

    function automatic bit m_valid(); return have && cyc >= ready_cyc; endfunction
    function automatic bit m_busy();  return have && cyc < ready_cyc;  endfunction
    function automatic bit m_ready(); return !have || (m_valid() && OutReady); endfunction

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            have = 1'b0; m_ctrl = '0; m_ill = 1'b0;
        end else begin
            if (InValid && m_ready()) begin
                ref_dec(ALUop, Opcode, d_c, d_il, d_lat);
                m_ctrl = d_c; m_ill = d_il; have = 1'b1; ready_cyc = cyc + d_lat;
            end else if (m_valid() && OutReady) begin
                have = 1'b0;
            end
            cyc++;
        end
    end

    always @(negedge Clk) begin
        chk4("model ctrl", ALUCtrl, m_ctrl);
        chk1("model out_valid", OutValid, m_valid());
        chk1("model busy", Busy, m_busy());
        chk1("model in_ready", InReady, m_ready());
        if (m_valid()) chk1("model illegal", Illegal, m_ill);
    end

    task automatic issue(input logic [1:0] a, input logic [10:0] op);
        @(posedge Clk); #1;
        ALUop = a; Opcode = op; InValid = 1'b1;
    endtask

    task automatic idle();
        @(posedge Clk); #1;
        InValid = 1'b0;
    endtask

    localparam int N = 15;
    localparam logic [1:0]  T_A   [0:N-1] = '{2, 2, 2, 2, 2, 2, 2, 3, 3, 3, 3, 0, 1, 2, 3};
    localparam logic [10:0] T_OP  [0:N-1] = '{11'b11001011000, 11'b10001011000, 11'b10001010000, 11'b10101010000,
                                              11'b11001010000, 11'b11010011011, 11'b11010011010, 11'b10010001000,
                                              11'b11010001001, 11'b10010010000, 11'b10110010001, 11'b11111000010,
                                              11'b10110100000, 11'b00000000000, 11'b00000000000};
    localparam logic [3:0]  T_EXP [0:N-1] = '{4'b0110, 4'b0010, 4'b0000, 4'b0001, 4'b0011, 4'b1000, 4'b1001,
                                              4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0010, 4'b0111, 4'b1111, 4'b1111};
    localparam bit          T_ILL [0:N-1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};

    initial begin
        #1 Reset = 1'b1;
        repeat (2) @(negedge Clk);
        #2 Reset = 1'b0;
        idle();
        chk1("in_ready after reset", InReady, 1'b1);
        for (int i = 0; i < N; i++) begin
            issue(T_A[i], T_OP[i]);
            idle();
            chk4($sformatf("op%0d ctrl", i), ALUCtrl, T_EXP[i]);
            chk1($sformatf("op%0d out_valid", i), OutValid, 1'b1);
            chk1($sformatf("op%0d illegal", i), Illegal, T_ILL[i]);
        end
        issue(2'd2, 11'b10001011000);
        issue(2'd2, 11'b11001011000);
        chk4("b2b add", ALUCtrl, 4'b0010);
        chk1("b2b in_ready", InReady, 1'b1);
        issue(2'd3, 11'b10110010000);
        chk4("b2b sub", ALUCtrl, 4'b0110);
        chk1("b2b in_ready 2", InReady, 1'b1);
        idle();
        chk4("b2b orri", ALUCtrl, 4'b0001);
        chk1("b2b out_valid", OutValid, 1'b1);
        issue(2'd2, 11'b11001011000);
        idle();
        OutReady = 1'b0;
        ALUop = 2'd2; Opcode = 11'b10001011000; InValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk4("hold ctrl", ALUCtrl, 4'b0110);
            chk1("hold out_valid", OutValid, 1'b1);
            chk1("hold in_ready", InReady, 1'b0);
            @(posedge Clk);
        end
        #1 OutReady = 1'b1;
        #1 chk1("release in_ready", InReady, 1'b1);
        @(posedge Clk); #1;
        InValid = 1'b0;
        chk4("after hold add", ALUCtrl, 4'b0010);
        issue(2'd2, MUL_OP);
        idle();
        if (MUL_EN) begin
            for (int i = 0; i < MULC; i++) begin
                chk1("mul busy", Busy, 1'b1);
                chk1("mul in_ready", InReady, 1'b0);
                chk1("mul out_valid", OutValid, 1'b0);
                chk4("mul ctrl", ALUCtrl, 4'b1100);
                @(posedge Clk); #1;
            end
            chk1("mul done valid", OutValid, 1'b1);
            chk1("mul done busy", Busy, 1'b0);
            chk4("mul done ctrl", ALUCtrl, 4'b1100);
            chk1("mul done illegal", Illegal, 1'b0);
        end else begin
            chk4("mul off ctrl", ALUCtrl, 4'b1111);
            chk1("mul off illegal", Illegal, 1'b1);
            chk1("mul off valid", OutValid, 1'b1);
            chk1("mul off busy", Busy, 1'b0);
        end
        issue(2'd2, MUL_OP);
        idle();
        #2 Reset = 1'b1;
        #1;
        chk4("reset ctrl", ALUCtrl, 4'b0000);
        chk1("reset out_valid", OutValid, 1'b0);
        chk1("reset illegal", Illegal, 1'b0);
        chk1("reset busy", Busy, 1'b0);
        @(negedge Clk); #2 Reset = 1'b0;
        repeat (MULC + 2) begin
            @(posedge Clk); #1;
            chk1("post reset out_valid", OutValid, 1'b0);
            chk1("post reset in_ready", InReady, 1'b1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/alu_control_seq.md
Name: alu_control_seq

Overview:
- Registered, handshaked successor to the single-cycle LEGv8 ALU control decoder.
- Decodes ALUop plus instruction opcode into a 4-bit ALU control word. Adds I-type, EOR, LSL/LSR and a multi-cycle MUL.
- Sequences MUL over a parametrised number of cycles and holds its result until downstream accepts it.
- Sits between the main control unit and the ALU in the multi-cycle/pipelined datapath.

Parameters:
- OPCODE_W, 11, instruction opcode field width; minimum 11.
- CTRL_W, 4, ALU control word width; minimum 4.
- MUL_CYCLES, 4, cycles the MUL control word is held before OutValid; minimum 1.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ALUop  in  2  operation class from main control.
- Opcode  in  OPCODE_W  instruction bits [31:21].
- InValid  in  1  ALUop/Opcode valid.
- InReady  out  1  block can accept; transfer when InValid && InReady.
- ALUCtrl  out  CTRL_W  registered ALU control word.
- OutValid  out  1  ALUCtrl final and consumable.
- OutReady  in  1  downstream accepts; transfer when OutValid && OutReady.
- Busy  out  1  multi-cycle operation in progress.
- Illegal  out  1  decoded op was undefined; valid with OutValid.

Behaviour:
- Reset (async):
  - State IDLE; ALUCtrl=0, OutValid=0, Illegal=0, Busy=0, counter=0.
  - InReady=1 once Reset deasserts.
  - Reset mid-MULTI or mid-VALID aborts the op; no OutValid is produced.
- Decode (low 4 bits of ALUCtrl; upper CTRL_W-4 bits zero):
  - ALUop=00 -> 0010 (LDUR/STUR address add).
  - ALUop=01 -> 0111 (CBZ pass-B).
  - ALUop=10, full Opcode:
    - 10001011000 ADD -> 0010
    - 11001011000 SUB -> 0110
    - 10001010000 AND -> 0000
    - 10101010000 ORR -> 0001
    - 11001010000 EOR -> 0011
    - 11010011011 LSL -> 1000
    - 11010011010 LSR -> 1001
    - 10011011000 MUL -> 1100 (multi-cycle)
  - ALUop=11, Opcode[10:1]:
    - 1001000100 ADDI -> 0010
    - 1101000100 SUBI -> 0110
    - 1001001000 ANDI -> 0000
    - 1011001000 ORRI -> 0001
  - Any other combination -> ALUCtrl=1111, Illegal=1; handled as a single-cycle op.
- FSM states: IDLE, MULTI, VALID.
  - InReady = (state==IDLE) || (state==VALID && OutReady). Combinational from state and OutReady.
  - Accept, single-cycle op: at the accept edge, ALUCtrl/Illegal load and state -> VALID. OutValid is high in the next cycle, so latency is 1.
  - Accept, MUL: at the accept edge, ALUCtrl=1100, Illegal=0, counter=MUL_CYCLES-1, state -> MULTI.
  - MULTI: Busy=1, OutValid=0, ALUCtrl stable. Each edge, if counter==0 go to VALID, else decrement. OutValid rises exactly MUL_CYCLES edges after the accept edge.
  - VALID: OutValid=1; ALUCtrl/Illegal held while OutReady=0.
    - OutReady=1 with InValid=1: new op accepted in the same cycle (back-to-back, no bubble).
    - OutReady=1 with InValid=0: state -> IDLE, OutValid=0; ALUCtrl keeps its last value.
  - MULTI ignores InValid; InReady=0 there.
- Simultaneous Reset and accept: Reset wins.
- Counter width is clog2(MUL_CYCLES+1).

Optional Feature:
- Macro ALUCTL_MUL_EN.
- Defined: MUL is decoded and sequenced as above.
- Undefined:
  - MUL opcode decodes as illegal (1111, Illegal=1, 1-cycle latency).
  - MULTI state, counter and MUL_CYCLES logic are not synthesised.
  - Busy is tied 0.

Test Plan:
- Reset asserted mid-cycle -> ALUCtrl=0000, OutValid=0, Illegal=0, Busy=0 immediately; InReady=1 after release.
- ALUop=10, Opcode=11001011000, InValid=1, OutReady=1 -> next cycle ALUCtrl=0110, OutValid=1, Illegal=0. Repeat for ADD/AND/ORR/EOR/LSL/LSR and the four ALUop=11 immediates.
- Back-to-back stream ADD, SUB, ORRI with OutReady=1 -> one result per cycle: 0010, 0110, 0001; InReady stays 1.
- MUL (10011011000), MUL_CYCLES=4, with ALUCTL_MUL_EN:
  - Busy=1 for 4 cycles, InReady=0 throughout.
  - OutValid rises on the 4th edge after accept, ALUCtrl=1100.
  - Same stimulus without the macro -> ALUCtrl=1111, Illegal=1 after 1 cycle.
- OutReady held 0 for 3 cycles after SUB -> ALUCtrl=0110 and OutValid stable; InReady=0; new InValid ignored until OutReady=1.
- ALUop=10, Opcode=00000000000 -> ALUCtrl=1111, Illegal=1. Reset asserted during MULTI -> no OutValid; state IDLE.
